// File: rtl/cat_rec_sequencer_pkg.sv
// rtl/cat_rec_sequencer_pkg.sv - shared FSM encoding and CTRL/STATUS bit positions
package cat_rec_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_RESULT = 3'd4,
    ST_LATCH  = 3'd5
  } state_t;

  localparam int CTRL_START      = 0;
  localparam int CTRL_CLEAR_DONE = 1;
  localparam int CTRL_ABORT      = 2;

  localparam int STAT_RESULT = 0;
  localparam int STAT_BUSY   = 1;
  localparam int STAT_DONE   = 2;

endpackage

// File: rtl/cat_rec_sequencer_if.sv
// rtl/cat_rec_sequencer_if.sv - APB bus bundle between host and the sequencer
interface cat_rec_sequencer_if #(
  parameter int AMBA_WORD       = 24,
  parameter int AMBA_ADDR_DEPTH = 12
);

  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [AMBA_ADDR_DEPTH-1:0] PADDR;
  logic [AMBA_WORD-1:0]       PWDATA;
  logic [AMBA_WORD-1:0]       PRDATA;
  logic                       PREADY;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY
  );

endinterface

// File: rtl/cat_rec_sequencer_stream_counter.sv
// rtl/cat_rec_sequencer_stream_counter.sv - loadable up-counter flagging its last value
module rec_stream_counter #(
  parameter int WIDTH = 12,
  parameter int LAST  = 4094
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  localparam logic [WIDTH-1:0] LAST_V = WIDTH'(LAST);

  assign last = (count == LAST_V);

  // Wraps straight back to zero at LAST so it never runs past the stream length
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en) begin
      count <= last ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/cat_rec_sequencer.sv
// rtl/cat_rec_sequencer.sv - APB front end and compute scheduler for the cat recognizer
// Optional CTRL abort bit enabled by defining CAT_REC_ABORT_EN.
module cat_rec_sequencer
  import cat_rec_pkg::*;
#(
  parameter int AMBA_WORD       = 24,
  parameter int AMBA_ADDR_DEPTH = 12,
  parameter int NUM_WORDS       = 4095,
  parameter int CTRL_ADDR       = 2**AMBA_ADDR_DEPTH - 1
) (
  input  logic                       clk,
  input  logic                       rst,
  cat_rec_sequencer_if.slave         apb,
  output logic [AMBA_ADDR_DEPTH-1:0] mem_addr,
  output logic                       mem_wr_en,
  output logic [AMBA_WORD-1:0]       mem_wdata,
  output logic                       mem_rd_en,
  output logic                       calc_clear,
  output logic                       calc_en,
  output logic                       get_result,
  input  logic                       calc_out,
  output logic                       cat_rec_out,
  output logic                       busy,
  output logic                       done_irq
);

  localparam logic [AMBA_ADDR_DEPTH-1:0] CTRL_A = AMBA_ADDR_DEPTH'(CTRL_ADDR);
  localparam logic [AMBA_ADDR_DEPTH-1:0] NW_A   = AMBA_ADDR_DEPTH'(NUM_WORDS);

  state_t                     state, state_next;
  logic                       access, ctrl_hit, ctrl_wr, ctrl_rd, mem_wr_req;
  logic                       busy_int, start_ok, abort_req, latch_now;
  logic                       cnt_en, cnt_load, cnt_last;
  logic [AMBA_ADDR_DEPTH-1:0] cnt;
  logic                       done;
  logic [AMBA_WORD-1:0]       status;

  assign access     = apb.PSEL & apb.PENABLE;
  assign ctrl_hit   = (apb.PADDR == CTRL_A);
  assign ctrl_wr    = access & apb.PWRITE & ctrl_hit;
  assign ctrl_rd    = access & ~apb.PWRITE & ctrl_hit;
  assign mem_wr_req = access & apb.PWRITE & ~ctrl_hit;
  assign busy_int   = (state != ST_IDLE);
  assign start_ok   = ctrl_wr & apb.PWDATA[CTRL_START] & ~busy_int;

`ifdef CAT_REC_ABORT_EN
  assign abort_req = ctrl_wr & apb.PWDATA[CTRL_ABORT] & busy_int;
`else
  assign abort_req = 1'b0;
`endif

  // Pixel writes would collide with streaming reads on the shared address, so hold them off
  assign apb.PREADY = ~(apb.PSEL & apb.PWRITE & ~ctrl_hit & busy_int);
  assign mem_wr_en  = mem_wr_req & ~busy_int & (apb.PADDR < NW_A);
  assign mem_wdata  = apb.PWDATA;
  assign mem_addr   = busy_int ? cnt : apb.PADDR;
  assign busy       = busy_int;
  assign latch_now  = (state == ST_LATCH) & ~abort_req;

  always_comb begin
    status              = '0;
    status[STAT_RESULT] = cat_rec_out;
    status[STAT_BUSY]   = busy_int;
    status[STAT_DONE]   = done;
  end

  assign apb.PRDATA = ctrl_rd ? status : '0;

  rec_stream_counter #(
    .WIDTH (AMBA_ADDR_DEPTH),
    .LAST  (NUM_WORDS - 1)
  ) u_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_value ('0),
    .en         (cnt_en),
    .count      (cnt),
    .last       (cnt_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    calc_clear = 1'b0;
    mem_rd_en  = 1'b0;
    get_result = 1'b0;
    cnt_en     = 1'b0;
    cnt_load   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_next = ST_CLEAR;
      end
      ST_CLEAR: begin
        calc_clear = 1'b1;
        state_next = ST_STREAM;
      end
      ST_STREAM: begin
        mem_rd_en = 1'b1;
        cnt_en    = 1'b1;
        if (cnt_last) state_next = ST_DRAIN;
      end
      ST_DRAIN:  state_next = ST_RESULT;
      ST_RESULT: begin
        get_result = 1'b1;
        state_next = ST_LATCH;
      end
      ST_LATCH:  state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    if (abort_req) begin
      state_next = ST_IDLE;
      cnt_load   = 1'b1;
    end
  end

  // A completion in the same cycle as clear_done wins: the fresh result must not be lost
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      calc_en     <= 1'b0;
      cat_rec_out <= 1'b0;
      done        <= 1'b0;
      done_irq    <= 1'b0;
    end else begin
      calc_en  <= mem_rd_en;
      done_irq <= 1'b0;
      if ((ctrl_wr & apb.PWDATA[CTRL_CLEAR_DONE]) | start_ok) done <= 1'b0;
      if (latch_now) begin
        cat_rec_out <= calc_out;
        done        <= 1'b1;
        done_irq    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cat_rec_sequencer.sv
// tb/tb_cat_rec_sequencer.sv - self-checking bench for cat_rec_sequencer with NUM_WORDS=4
module tb_cat_rec_sequencer;

  localparam int AW = 12;
  localparam int DW = 24;
  localparam int N  = 4;
  localparam logic [AW-1:0] CTRL = 12'hFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] mem_addr;
  logic          mem_wr_en;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd_en, calc_clear, calc_en, get_result;
  logic          calc_out = 1'b0;
  logic          cat_rec_out, busy, done_irq;

  always #5 clk = ~clk;

  cat_rec_sequencer_if #(.AMBA_WORD(DW), .AMBA_ADDR_DEPTH(AW)) apb ();

  cat_rec_sequencer #(
    .AMBA_WORD(DW), .AMBA_ADDR_DEPTH(AW), .NUM_WORDS(N), .CTRL_ADDR(4095)
  ) dut (
    .clk(clk), .rst(rst), .apb(apb),
    .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata),
    .mem_rd_en(mem_rd_en), .calc_clear(calc_clear), .calc_en(calc_en),
    .get_result(get_result), .calc_out(calc_out), .cat_rec_out(cat_rec_out),
    .busy(busy), .done_irq(done_irq)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is a fixed schedule of offsets from the edge that accepted start
  int cyc = 0, s = 0;
  bit active = 0, m_done = 0, m_cat = 0, m_irq = 0, m_prev_rd = 0;
  bit mb, mcw;

  function bit m_busy();
    return active && (cyc - s) <= N + 3;
  endfunction

  function bit m_rd();
    return active && (cyc - s) >= 1 && (cyc - s) <= N;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      active = 0; m_done = 0; m_cat = 0; m_irq = 0; m_prev_rd = 0;
    end else begin
      mb        = m_busy();
      m_prev_rd = m_rd();
      mcw       = apb.PSEL && apb.PENABLE && apb.PWRITE && apb.PADDR == CTRL;
      cyc++;
      m_irq = 0;
      if (mcw && apb.PWDATA[1]) m_done = 0;
`ifdef CAT_REC_ABORT_EN
      if (mcw && apb.PWDATA[2] && mb) active = 0;
`endif
      if (active && cyc - s == N + 4) begin
        active = 0; m_done = 1; m_cat = calc_out; m_irq = 1;
      end
      if (mcw && apb.PWDATA[0] && !mb) begin
        active = 1; s = cyc; m_done = 0;
      end
    end
  end

  int  cj;
  bit  cacc;
  always @(negedge clk) begin
    cj   = cyc - s;
    cacc = apb.PSEL && apb.PENABLE;
    chk("busy", busy, m_busy());
    chk("calc_clear", calc_clear, active && cj == 0);
    chk("mem_rd_en", mem_rd_en, m_rd());
    if (m_rd()) chk("mem_addr_stream", mem_addr, cj - 1);
    if (!m_busy()) chk("mem_addr_idle", mem_addr, apb.PADDR);
    chk("calc_en", calc_en, m_prev_rd);
    chk("get_result", get_result, active && cj == N + 2);
    chk("done_irq", done_irq, m_irq);
    chk("cat_rec_out", cat_rec_out, m_cat);
    chk("PREADY", apb.PREADY, !(apb.PSEL && apb.PWRITE && apb.PADDR != CTRL && m_busy()));
    chk("mem_wr_en", mem_wr_en, cacc && apb.PWRITE && apb.PADDR < N && !m_busy());
    chk("mem_wdata", mem_wdata, apb.PWDATA);
    chk("PRDATA", apb.PRDATA,
        (cacc && !apb.PWRITE && apb.PADDR == CTRL) ? {m_done, m_busy(), m_cat} : 3'b000);
  end

  int irq_count = 0;
  always @(negedge clk) if (done_irq) irq_count++;

  task automatic apb_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output int waits, output logic wr, output logic [AW-1:0] wa);
    @(posedge clk); #1;
    apb.PSEL = 1; apb.PENABLE = 0; apb.PWRITE = 1; apb.PADDR = a; apb.PWDATA = d;
    @(posedge clk); #1;
    apb.PENABLE = 1; waits = 0;
    @(negedge clk);
    while (!apb.PREADY && waits < 100) begin waits++; @(negedge clk); end
    wr = mem_wr_en; wa = mem_addr;
    @(posedge clk); #1;
    apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0;
  endtask

  task automatic apb_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    int waits;
    @(posedge clk); #1;
    apb.PSEL = 1; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = a;
    @(posedge clk); #1;
    apb.PENABLE = 1; waits = 0;
    @(negedge clk);
    while (!apb.PREADY && waits < 100) begin waits++; @(negedge clk); end
    d = apb.PRDATA;
    @(posedge clk); #1;
    apb.PSEL = 0; apb.PENABLE = 0;
  endtask

  // Called right after a start write returns; k counts cycles from the start edge to done_irq
  task automatic measure(output int k, output int n_en, output int n_get, output logic [47:0] addrs);
    k = 0; n_en = 0; n_get = 0; addrs = '0;
    @(negedge clk);
    while (!done_irq && k < 50) begin
      if (mem_rd_en) addrs = {addrs[35:0], mem_addr};
      if (calc_en) n_en++;
      if (get_result) n_get++;
      k++;
      @(negedge clk);
    end
  endtask

  int              w, k, n_en, n_get, irq0, cnt;
  logic            wr;
  logic [AW-1:0]   wa;
  logic [DW-1:0]   rd;
  logic [47:0]     addrs;

  initial begin
    apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0; apb.PADDR = '0; apb.PWDATA = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cat", cat_rec_out, 1'b0);
    chk("rst_irq", done_irq, 1'b0);
    rst = 0;

    // 1: fill pixels, run once, check schedule and latency
    for (int i = 0; i < N; i++) begin
      apb_write(AW'(i), DW'(24'h100 + i), w, wr, wa);
      chk("t1_wr_en", wr, 1'b1);
      chk("t1_wr_addr", wa, AW'(i));
    end
    calc_out = 1;
    apb_write(CTRL, 24'd1, w, wr, wa);
    chk("t1_start_waits", w, 0);
    measure(k, n_en, n_get, addrs);
    chk("t1_latency", k, 8);
    chk("t1_calc_en_cycles", n_en, 4);
    chk("t1_get_result_cycles", n_get, 1);
    chk("t1_addr_seq", addrs[31:0], 32'h0100_2003);
    chk("t1_addr_seq_hi", addrs[47:32], 16'h0000);
    chk("t1_cat", cat_rec_out, 1'b1);

    // 2: status readback and clear_done
    apb_read(CTRL, rd);
    chk("t2_status_done", rd, 24'd5);
    apb_write(CTRL, 24'd2, w, wr, wa);
    apb_read(CTRL, rd);
    chk("t2_status_cleared", rd, 24'd1);

    // 3: restart ignored while busy, pixel write stalls until idle
    irq0 = irq_count;
    apb_write(CTRL, 24'd1, w, wr, wa);
    apb_write(CTRL, 24'd1, w, wr, wa);
    chk("t3_ctrl_zero_wait", w, 0);
    apb_write(AW'(2), 24'hABCDEF, w, wr, wa);
    chk("t3_stall_waits", w, 3);
    chk("t3_stalled_wr_en", wr, 1'b1);
    chk("t3_stalled_wr_addr", wa, AW'(2));
    repeat (20) @(negedge clk);
    chk("t3_single_run", irq_count - irq0, 1);
    apb_read(CTRL, rd);
    chk("t3_status", rd, 24'd5);

    // 4: asynchronous reset mid-stream, then a clean full run
    apb_write(CTRL, 24'd1, w, wr, wa);
    cnt = 0;
    @(negedge clk);
    while (!(mem_rd_en && mem_addr == AW'(2)) && cnt < 20) begin cnt++; @(negedge clk); end
    chk("t4_reach_cnt2", cnt < 20, 1'b1);
    chk("t4_cat_before", cat_rec_out, 1'b1);
    #2 rst = 1;
    #1;
    chk("t4_async_busy", busy, 1'b0);
    chk("t4_async_rd_en", mem_rd_en, 1'b0);
    chk("t4_async_calc_en", calc_en, 1'b0);
    chk("t4_async_cat", cat_rec_out, 1'b0);
    @(negedge clk);
    rst = 0;
    calc_out = 0;
    apb_write(CTRL, 24'd1, w, wr, wa);
    measure(k, n_en, n_get, addrs);
    chk("t4_latency", k, 8);
    chk("t4_addr_seq", addrs[31:0], 32'h0100_2003);
    chk("t4_calc_en_cycles", n_en, 4);
    apb_read(CTRL, rd);
    chk("t4_status", rd, 24'd4);

    // 5: out-of-range write dropped, non-CTRL read is zero
    apb_write(AW'(10), 24'h5A5A5A, w, wr, wa);
    chk("t5_waits", w, 0);
    chk("t5_wr_dropped", wr, 1'b0);
    apb_read(AW'(0), rd);
    chk("t5_read_zero", rd, 24'd0);

    // 6: abort while streaming at counter 1
    calc_out = 1;
    irq0 = irq_count;
    apb_write(CTRL, 24'd1, w, wr, wa);
    apb_write(CTRL, 24'd4, w, wr, wa);
    cnt = 0;
    @(negedge clk);
`ifdef CAT_REC_ABORT_EN
    chk("t6_abort_idle", busy, 1'b0);
`else
    chk("t6_no_abort_busy", busy, 1'b1);
`endif
    repeat (15) begin
      if (get_result) cnt++;
      @(negedge clk);
    end
`ifdef CAT_REC_ABORT_EN
    chk("t6_no_get_result", cnt, 0);
    chk("t6_no_irq", irq_count - irq0, 0);
    chk("t6_cat_held", cat_rec_out, 1'b0);
`else
    chk("t6_get_result", cnt, 1);
    chk("t6_irq", irq_count - irq0, 1);
    chk("t6_cat_new", cat_rec_out, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
